// File: rtl/mem_ctrl_arb.sv
// Byte-serial RAM/IO bus controller: arbitrates icache line fetches against LSB loads/stores.
// Define MEM_LOAD_SIGN_EXT_EN to add the ls_signed input (sign-extended loads).
module mem_ctrl_arb #(
  parameter int                ADDR_W     = 32,
  parameter int                LINE_BYTES = 16,
  parameter logic [ADDR_W-1:0] IO_MASK    = ADDR_W'(32'h00030000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [7:0]              mem_in,
  output logic [7:0]              mem_out,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [2:0]              ls_len,
  input  logic [31:0]             ls_wdata,
`ifdef MEM_LOAD_SIGN_EXT_EN
  input  logic                    ls_signed,
`endif
  output logic                    ls_done,
  output logic [31:0]             ls_rdata
);
  localparam int BUF_B = (LINE_BYTES > 4) ? LINE_BYTES : 4;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {IDLE, READ, STORE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt, n_q, n_nxt;
  logic [ADDR_W-1:0]       base, base_nxt, mem_addr_nxt, cur_addr;
  logic                    fetch_q, fetch_nxt, gap, gap_nxt, cur_io;
  logic [31:0]             wdata, wdata_nxt, rdata_nxt;
  logic [BUF_B*8-1:0]      line_q, line_nxt, line_cap;
  logic [LINE_BYTES*8-1:0] if_data_nxt;
  logic [7:0]              mem_out_nxt;
  logic                    mem_wr_nxt, if_done_nxt, ls_done_nxt;
  logic                    can_acc, acc_ls, acc_if;

  // Mandatory one-cycle gap after any done pulse; rollback also blocks acceptance.
  assign can_acc  = (state == IDLE) && !if_done && !ls_done && !rollback;
  assign acc_ls   = can_acc && ls_req;
  assign acc_if   = can_acc && !ls_req && if_req;
  assign cur_addr = base + ADDR_W'(cnt);
  assign cur_io   = (cur_addr & IO_MASK) == IO_MASK;

`ifdef MEM_LOAD_SIGN_EXT_EN
  logic sgn_q;
  always_ff @(posedge clk)
    if (rst)                sgn_q <= 1'b0;
    else if (rdy && acc_ls) sgn_q <= ls_signed;
`else
  logic sgn_q;
  assign sgn_q = 1'b0;
`endif

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [CNT_W-1:0] n,
                                         input logic s);
    logic [31:0] r;
    if (n == CNT_W'(1))      r = {{24{s & d[7]}}, d[7:0]};
    else if (n == CNT_W'(2)) r = {{16{s & d[15]}}, d[15:0]};
    else if (n == CNT_W'(3)) r = {{8{s & d[23]}}, d[23:0]};
    else                     r = d;
    return r;
  endfunction

  always_comb begin
    line_cap = line_q;
    line_cap[8*cnt +: 8] = mem_in;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    n_nxt        = n_q;
    base_nxt     = base;
    fetch_nxt    = fetch_q;
    gap_nxt      = gap;
    wdata_nxt    = wdata;
    line_nxt     = line_q;
    mem_addr_nxt = mem_addr;
    mem_out_nxt  = mem_out;
    mem_wr_nxt   = mem_wr;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data;
    rdata_nxt    = ls_rdata;
    case (state)
      IDLE: begin
        mem_wr_nxt = 1'b0;
        if (acc_ls) begin
          base_nxt  = ls_addr;
          n_nxt     = (ls_len == 3'd0) ? CNT_W'(1) : CNT_W'(ls_len);
          fetch_nxt = 1'b0;
          wdata_nxt = ls_wdata;
          cnt_nxt   = '0;
          gap_nxt   = 1'b0;
          if (ls_wr) state_nxt = STORE;
          else begin
            state_nxt    = READ;
            mem_addr_nxt = ls_addr;
          end
        end else if (acc_if) begin
          base_nxt     = if_addr;
          n_nxt        = CNT_W'(LINE_BYTES);
          fetch_nxt    = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = READ;
          mem_addr_nxt = if_addr;
        end
      end
      READ: begin
        if (rollback) begin
          state_nxt    = IDLE;
          mem_addr_nxt = '0;
          cnt_nxt      = '0;
        end else begin
          line_nxt = line_cap;
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt_nxt == n_q) begin
            state_nxt    = IDLE;
            mem_addr_nxt = '0;
            if (fetch_q) begin
              if_done_nxt = 1'b1;
              if_data_nxt = line_cap[LINE_BYTES*8-1:0];
            end else begin
              ls_done_nxt = 1'b1;
              rdata_nxt   = extend(line_cap[31:0], n_q, sgn_q);
            end
          end else begin
            mem_addr_nxt = cur_addr + ADDR_W'(1);
          end
        end
      end
      STORE: begin
        if (cnt == n_q) begin
          state_nxt    = IDLE;
          mem_wr_nxt   = 1'b0;
          mem_addr_nxt = '0;
          ls_done_nxt  = 1'b1;
        end else if (gap || (cur_io && io_buffer_full)) begin
          // UART full flag lags a cycle, so every IO byte is followed by a dead bus cycle.
          mem_wr_nxt   = 1'b0;
          mem_addr_nxt = cur_addr;
          gap_nxt      = 1'b0;
        end else begin
          mem_wr_nxt   = 1'b1;
          mem_addr_nxt = cur_addr;
          mem_out_nxt  = wdata[8*cnt[1:0] +: 8];
          cnt_nxt      = cnt + CNT_W'(1);
          gap_nxt      = cur_io;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n_q      <= '0;
      base     <= '0;
      fetch_q  <= 1'b0;
      gap      <= 1'b0;
      wdata    <= '0;
      line_q   <= '0;
      mem_addr <= '0;
      mem_out  <= '0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      n_q      <= n_nxt;
      base     <= base_nxt;
      fetch_q  <= fetch_nxt;
      gap      <= gap_nxt;
      wdata    <= wdata_nxt;
      line_q   <= line_nxt;
      mem_addr <= mem_addr_nxt;
      mem_out  <= mem_out_nxt;
      mem_wr   <= mem_wr_nxt;
      if_done  <= if_done_nxt;
      ls_done  <= ls_done_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= rdata_nxt;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboard bench for mem_ctrl_arb: stimulus pushes expectations, a negedge monitor compares.
module tb_mem_ctrl_arb;
  localparam int AW = 32;
  localparam int LB = 4;

  logic          clk, rst, rdy, rollback, mem_wr, io_buffer_full;
  logic          if_req, if_done, ls_req, ls_wr, ls_done;
  logic [7:0]    mem_in, mem_out;
  logic [AW-1:0] mem_addr, if_addr, ls_addr;
  logic [LB*8-1:0] if_data;
  logic [2:0]    ls_len;
  logic [31:0]   ls_wdata, ls_rdata;
`ifdef MEM_LOAD_SIGN_EXT_EN
  logic          ls_signed;
`endif

  mem_ctrl_arb #(.ADDR_W(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_in(mem_in), .mem_out(mem_out), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
`ifdef MEM_LOAD_SIGN_EXT_EN
    .ls_signed(ls_signed),
`endif
    .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 KiB RAM, address aliased on the low 10 bits; read data is combinational.
  logic [7:0] ram [0:1023];
  logic       full_q;
  assign mem_in = ram[mem_addr[9:0]];

  always @(posedge clk) begin
    full_q <= io_buffer_full;
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h00; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h93;
      ram[10'h200] <= 8'hEF; ram[10'h201] <= 8'hBE; ram[10'h202] <= 8'hAD; ram[10'h203] <= 8'hDE;
      ram[10'h204] <= 8'h34; ram[10'h205] <= 8'h92; ram[10'h040] <= 8'h80;
    end else if (rdy && mem_wr) begin
      ram[mem_addr[9:0]] <= mem_out;
    end
  end

  typedef struct { bit chk; logic [31:0] d; } ls_exp_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  ls_exp_t     exp_ls[$];
  logic [31:0] exp_if[$];
  logic [39:0] exp_wr[$];
  chk_t        chk_q[$];
  int          n_run = 0, n_fail = 0;

  task automatic compare(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  ls_exp_t     m_ls;
  logic [31:0] m_if;
  logic [39:0] m_wr;
  chk_t        m_c;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      compare(m_c.name, m_c.act, m_c.exp);
    end
    if (!rst) begin
      if (ls_done) begin
        if (exp_ls.size() == 0) compare("ls_done_spurious", 64'd1, 64'd0);
        else begin
          m_ls = exp_ls.pop_front();
          if (m_ls.chk) compare("ls_rdata", {32'd0, ls_rdata}, {32'd0, m_ls.d});
        end
      end
      if (if_done) begin
        if (exp_if.size() == 0) compare("if_done_spurious", 64'd1, 64'd0);
        else begin
          m_if = exp_if.pop_front();
          compare("if_data", {32'd0, if_data}, {32'd0, m_if});
        end
      end
      if (mem_wr) begin
        if (exp_wr.size() == 0) compare("bus_write_spurious", 64'd1, 64'd0);
        else begin
          m_wr = exp_wr.pop_front();
          compare("bus_write_addr_data", {24'd0, mem_addr, mem_out}, {24'd0, m_wr});
        end
        if ((mem_addr & 32'h00030000) == 32'h00030000)
          compare("io_write_while_full", {63'd0, full_q}, 64'd0);
      end
    end
  end

  task automatic post(input string nm, input logic [63:0] a, input logic [63:0] e);
    chk_t c;
    c.name = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_ls(input bit wr, input logic [31:0] a, input logic [2:0] len,
                          input logic [31:0] wd, input bit sgn);
    ls_req = 1'b1; ls_wr = wr; ls_addr = a; ls_len = len; ls_wdata = wd;
`ifdef MEM_LOAD_SIGN_EXT_EN
    ls_signed = sgn;
`endif
  endtask

  // Edge k=1 is the first edge after the request is driven; latency = edges after accept.
  task automatic wait_done(input bit fetch, input int full_drop, input int roll_set,
                           input int roll_clr, input int rdy_clr, input int rdy_set,
                           input logic [31:0] hold_addr, output int lat, output int nwr);
    int k;
    k = 0; lat = -1; nwr = 0;
    while (k < 40 && lat < 0) begin
      @(posedge clk); #1; k++;
      if (rdy_clr != 0 && rdy == 1'b0) post("rdy_hold_addr", {32'd0, mem_addr}, {32'd0, hold_addr});
      if (mem_wr) nwr++;
      if (fetch ? if_done : ls_done) begin
        lat = k - 1;
        if (fetch) if_req = 1'b0; else ls_req = 1'b0;
      end
      if (k == full_drop) io_buffer_full = 1'b0;
      if (k == roll_set)  rollback = 1'b1;
      if (k == roll_clr)  rollback = 1'b0;
      if (k == rdy_clr)   rdy = 1'b0;
      if (k == rdy_set)   rdy = 1'b1;
    end
    if (lat < 0) begin
      if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1; rollback = 1'b0;
    end
  endtask

  int lat, nwr;
  bit seen;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0;
    ls_len = 3'd0; ls_wdata = '0;
`ifdef MEM_LOAD_SIGN_EXT_EN
    ls_signed = 1'b0;
`endif
    idle(3);
    post("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    post("rst_mem_wr",   {63'd0, mem_wr}, 64'd0);
    post("rst_mem_out",  {56'd0, mem_out}, 64'd0);
    post("rst_if_done",  {63'd0, if_done}, 64'd0);
    post("rst_ls_done",  {63'd0, ls_done}, 64'd0);
    post("rst_ls_rdata", {32'd0, ls_rdata}, 64'd0);
    post("rst_if_data",  {32'd0, if_data}, 64'd0);
    rst = 1'b0;
    idle(1);

    // Fetch 4-byte line at 0x100
    exp_if.push_back(32'h93000013);
    if_req = 1'b1; if_addr = 32'h100;
    wait_done(1'b1, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("fetch_latency", lat, 64'd4);
    idle(1);
    post("fetch_done_one_cycle", {63'd0, if_done}, 64'd0);

    // Simultaneous requests: load wins, gap cycle, then the fetch
    idle(1);
    exp_ls.push_back('{1'b1, 32'hDEADBEEF});
    exp_if.push_back(32'h93000013);
    if_req = 1'b1; if_addr = 32'h100;
    issue_ls(1'b0, 32'h200, 3'd4, 32'h0, 1'b0);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("load_first_latency", lat, 64'd4);
    wait_done(1'b1, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("fetch_after_gap_latency", lat, 64'd5);

    // Store half across 0x1FF/0x200
    idle(2);
    exp_wr.push_back({32'h1FF, 8'hB6}); exp_wr.push_back({32'h200, 8'hA5});
    exp_ls.push_back('{1'b0, 32'h0});
    issue_ls(1'b1, 32'h1FF, 3'd2, 32'h0000A5B6, 1'b0);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("store_half_latency", lat, 64'd3);
    post("store_half_writes", nwr, 64'd2);

    // Store half at 0xFFFFFFFF wraps to 0; top byte is IO so a dead cycle follows it
    idle(1);
    exp_wr.push_back({32'hFFFFFFFF, 8'h88}); exp_wr.push_back({32'h0, 8'h77});
    exp_ls.push_back('{1'b0, 32'h0});
    issue_ls(1'b1, 32'hFFFFFFFF, 3'd2, 32'h00007788, 1'b0);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("wrap_store_latency", lat, 64'd4);
    post("wrap_store_writes", nwr, 64'd2);
    idle(1);
    exp_ls.push_back('{1'b1, 32'h00007788});
    issue_ls(1'b0, 32'hFFFFFFFF, 3'd2, 32'h0, 1'b0);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("wrap_load_latency", lat, 64'd2);

    // IO store under back-pressure
    idle(1);
    exp_wr.push_back({32'h00030000, 8'h41});
    exp_ls.push_back('{1'b0, 32'h0});
    io_buffer_full = 1'b1;
    issue_ls(1'b1, 32'h00030000, 3'd1, 32'h41, 1'b0);
    wait_done(1'b0, 5, 0, 0, 0, 0, 0, lat, nwr);
    post("io_store_latency", lat, 64'd6);
    post("io_store_writes", nwr, 64'd1);

    // Rollback on the 2nd byte of a fetch
    idle(1);
    if_req = 1'b1; if_addr = 32'h100;
    idle(1); idle(1);
    rollback = 1'b1;
    idle(1);
    rollback = 1'b0; if_req = 1'b0;
    post("rollback_addr_cleared", {32'd0, mem_addr}, 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if_done) seen = 1'b1;
    end
    post("rollback_no_if_done", {63'd0, seen}, 64'd0);
    exp_ls.push_back('{1'b1, 32'h00000093});
    issue_ls(1'b0, 32'h103, 3'd1, 32'h0, 1'b0);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("load_after_rollback_latency", lat, 64'd1);

    // Rollback during a store is ignored
    idle(1);
    exp_wr.push_back({32'h10, 8'h44}); exp_wr.push_back({32'h11, 8'h33});
    exp_wr.push_back({32'h12, 8'h22}); exp_wr.push_back({32'h13, 8'h11});
    exp_ls.push_back('{1'b0, 32'h0});
    issue_ls(1'b1, 32'h10, 3'd4, 32'h11223344, 1'b0);
    wait_done(1'b0, 0, 1, 3, 0, 0, 0, lat, nwr);
    post("store_rollback_latency", lat, 64'd5);
    post("store_rollback_writes", nwr, 64'd4);

    // Rollback in IDLE blocks acceptance for that cycle
    idle(1);
    rollback = 1'b1;
    exp_ls.push_back('{1'b1, 32'h00000013});
    issue_ls(1'b0, 32'h100, 3'd1, 32'h0, 1'b0);
    wait_done(1'b0, 0, 0, 1, 0, 0, 0, lat, nwr);
    post("idle_rollback_latency", lat, 64'd2);

    // rdy low for 3 cycles mid-load of byte 0x80
    idle(1);
`ifdef MEM_LOAD_SIGN_EXT_EN
    exp_ls.push_back('{1'b1, 32'hFFFFFF80});
`else
    exp_ls.push_back('{1'b1, 32'h00000080});
`endif
    issue_ls(1'b0, 32'h40, 3'd1, 32'h0, 1'b1);
    wait_done(1'b0, 0, 0, 0, 1, 4, 32'h40, lat, nwr);
    post("rdy_stall_latency", lat, 64'd4);

    // Half load 0x9234 with ls_signed requested
    idle(1);
`ifdef MEM_LOAD_SIGN_EXT_EN
    exp_ls.push_back('{1'b1, 32'hFFFF9234});
`else
    exp_ls.push_back('{1'b1, 32'h00009234});
`endif
    issue_ls(1'b0, 32'h204, 3'd2, 32'h0, 1'b1);
    wait_done(1'b0, 0, 0, 0, 0, 0, 0, lat, nwr);
    post("half_load_latency", lat, 64'd2);

    idle(2);
    post("scoreboard_drained", exp_ls.size() + exp_if.size() + exp_wr.size(), 64'd0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
